fetch_decode_stage: RTL and testbench
=====================================

FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 SHALL be parametrised: XLEN, default 32, instruction/PC width.
REQ-002 SHALL be parametrised: IMEM_DEPTH, default 1024, instruction memory words; word address width AW = log2(IMEM_DEPTH).
REQ-003 SHALL be parametrised: QDEPTH, default 2, instruction queue entries (power of 2, >= 2).
REQ-004 SHALL be parametrised: RESET_PC, default 0, word address fetched first after reset.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Ports, in order:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  AW  word address of the request.
- imem_rdata  in  XLEN  instruction word, valid exactly 1 cycle after the accepted request.
- redirect_valid  in  1  branch taken / PC redirect.
- redirect_pc  in  AW  new fetch word address.
- dec_valid  out  1  decoded instruction available.
- dec_ready  in  1  consumer accepts it.
- dec_pc  out  AW  word address of the decoded instruction.
- dec_instr  out  XLEN  raw instruction.
- ALUop  out  3  ALU operation.
- reg_write, mem_write, mem_read, mem_to_reg, branch  out  1 each  control bits.
- is_rtype, is_itype_load, is_itype_store, is_branch  out  1 each  class flags.
- illegal  out  1  opcode not recognised.

Function
REQ-007 The fetch PC SHALL increment by 1 per accepted request and wrap from IMEM_DEPTH-1 to 0.
REQ-008 imem_req SHALL be 1 only when the count of queued plus in-flight entries is less than QDEPTH, ensuring a response is never dropped.
REQ-009 The response SHALL be written into the queue together with its PC on the cycle after the request.
REQ-010 The queue SHALL be FIFO; dec_valid = queue not empty; the head is popped when dec_valid and dec_ready are both 1.
REQ-011 A simultaneous push and pop SHALL leave the count unchanged; a push to a full queue SHALL never occur (guaranteed by REQ-008).
REQ-012 Decode SHALL be combinational from the queue head, keyed on instr[6:0]:
- 0110011: R-type; is_rtype=1, reg_write=1, ALUop=funct3 (instr[14:12]).
- 0010011: I-ALU; reg_write=1, ALUop=funct3, no class flag.
- 0000011: load; is_itype_load=1, reg_write=1, mem_read=1, mem_to_reg=1, ALUop=000.
- 0100011: store; is_itype_store=1, mem_write=1, ALUop=000.
- 1100011: branch; is_branch=1, branch=1, ALUop=001.
- Any other opcode: illegal=1 and all other controls 0.
REQ-013 All control outputs SHALL be 0 whenever dec_valid=0.
REQ-014 On redirect_valid, the stage SHALL within the same cycle:
- flush the queue;
- discard any in-flight response;
- set the fetch PC to redirect_pc.
The first new request SHALL issue the next cycle, and dec_valid SHALL be 0 for at least 2 cycles after the redirect cycle.
REQ-015 A redirect coincident with a pop SHALL take priority; the popped entry is considered consumed.
REQ-016 The controller SHALL have states RUN (normal fetch), STALL (capacity full, imem_req=0) and FLUSH (one cycle after a redirect: discard the response, imem_req=1 at the new PC).
- RUN -> STALL when capacity is reached.
- STALL -> RUN on a pop.
- Any state -> FLUSH on redirect.
- FLUSH -> RUN otherwise.

Reset
REQ-017 Reset SHALL set: fetch PC = RESET_PC, queue empty, in-flight = 0, state = RUN, every output 0.
REQ-018 imem_req SHALL rise on the first clock edge after rst deasserts.
REQ-019 Reset asserted mid-operation SHALL discard queue contents and in-flight data, and produce no dec_valid pulse.

Structure
REQ-020 The opcode constants, ALUop encodings and state enum SHALL reside in the shared package fetch_decode_pkg.
REQ-021 The queue SHALL be a sub-module instr_queue (parametrised XLEN+AW width, QDEPTH); decode logic stays in the top module.

Verification
REQ-022 Reset then dec_ready=1 with memory holding ADD, LW, SW, BEQ at addresses 0-3 -> dec_pc 0,1,2,3 on consecutive cycles after a 2-cycle latency, with is_rtype, is_itype_load, is_itype_store, is_branch asserted in that order.
REQ-023 dec_ready=0 for 10 cycles -> queue fills to 2, imem_req=0, dec_pc holds 0; after release, 0,1,2 are delivered in order with none lost or duplicated.
REQ-024 redirect_valid with redirect_pc=100 while a response is in flight -> the stale instruction is never presented; the next dec_pc is 100.
REQ-025 Fetch PC reaching 1023 -> next dec_pc after 1023 is 0.
REQ-026 Opcode 1111111 -> illegal=1, all controls 0; rst pulsed mid-stream -> all outputs 0 immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// Shared opcode constants, ALU encodings, controller states and the decode
// control bundle for the fetch/decode stage.
package fetch_decode_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic       is_rtype;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/instr_queue.sv
// Small power-of-two FIFO holding {pc, instruction} pairs between fetch and
// decode. Flush wins over push and pop in the same cycle.
module instr_queue #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= push_data;
  end

  assign head_data = mem_q[rd_q];
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch with a small response queue, redirect flush and a
// combinational decoder on the queue head.
//
// state   | meaning
// S_RUN   | normal fetch, one request per cycle while capacity allows
// S_STALL | queue plus in-flight at capacity, waiting for a pop
// S_FLUSH | cycle after a redirect: drop the stale response, fetch new PC
module fetch_decode_stage
  import fetch_decode_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int IMEM_DEPTH = 1024,
  parameter  int QDEPTH     = 2,
  parameter  int RESET_PC   = 0,
  localparam int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [AW-1:0]   redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [AW-1:0]   dec_pc,
  output logic [XLEN-1:0] dec_instr,
  output logic [2:0]      ALUop,
  output logic            reg_write,
  output logic            mem_write,
  output logic            mem_read,
  output logic            mem_to_reg,
  output logic            branch,
  output logic            is_rtype,
  output logic            is_itype_load,
  output logic            is_itype_store,
  output logic            is_branch,
  output logic            illegal
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int QW = XLEN + AW;

  fetch_state_e    state_q, state_d;
  logic            started_q, started_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   pc_q, pc_d, req_pc_q, req_pc_d;
  logic            q_empty, push, pop_fire, discard, cap_ok;
  logic [CW-1:0]   q_count;
  logic [CW:0]     occ;
  logic [QW-1:0]   q_head;
  logic [AW-1:0]   head_pc;
  logic [XLEN-1:0] head_instr;
  ctrl_t           ctrl;

  assign {head_pc, head_instr} = q_head;
  assign dec_valid = ~q_empty;
  assign pop_fire  = dec_valid & dec_ready;
  assign discard   = redirect_valid | (state_q == S_FLUSH);
  assign push      = inflight_q & ~discard;

  // Occupancy once this cycle's response lands and the head leaves; a new
  // request is safe only if its response will still find a free slot.
  assign occ       = {1'b0, q_count} + (CW+1)'(push) - (CW+1)'(pop_fire);
  assign cap_ok    = occ < (CW+1)'(QDEPTH);
  assign imem_req  = started_q & cap_ok;
  assign imem_addr = imem_req ? pc_q : '0;

  always_comb begin
    started_d  = 1'b1;
    inflight_d = imem_req;
    req_pc_d   = imem_req ? pc_q : req_pc_q;
    pc_d       = pc_q;
    if (redirect_valid)
      pc_d = redirect_pc;
    else if (imem_req)
      pc_d = (pc_q == AW'(IMEM_DEPTH - 1)) ? '0 : pc_q + AW'(1);
    state_d = state_q;
    if (redirect_valid) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_RUN:   if (!cap_ok) state_d = S_STALL;
        S_STALL: if (pop_fire) state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      started_q  <= 1'b0;
      inflight_q <= 1'b0;
      pc_q       <= AW'(RESET_PC);
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      inflight_q <= inflight_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  instr_queue #(
    .WIDTH (QW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({req_pc_q, imem_rdata}),
    .pop       (pop_fire),
    .head_data (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  always_comb begin
    ctrl = '0;
    if (dec_valid) begin
      case (head_instr[6:0])
        OP_RTYPE: begin
          ctrl.is_rtype  = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = head_instr[14:12];
        end
        OP_IALU: begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = head_instr[14:12];
        end
        OP_LOAD: begin
          ctrl.is_load    = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.alu_op     = ALU_ADD;
        end
        OP_STORE: begin
          ctrl.is_store  = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.alu_op    = ALU_ADD;
        end
        OP_BRANCH: begin
          ctrl.is_branch = 1'b1;
          ctrl.branch    = 1'b1;
          ctrl.alu_op    = ALU_SUB;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

  assign dec_pc         = dec_valid ? head_pc : '0;
  assign dec_instr      = dec_valid ? head_instr : '0;
  assign ALUop          = ctrl.alu_op;
  assign reg_write      = ctrl.reg_write;
  assign mem_write      = ctrl.mem_write;
  assign mem_read       = ctrl.mem_read;
  assign mem_to_reg     = ctrl.mem_to_reg;
  assign branch         = ctrl.branch;
  assign is_rtype       = ctrl.is_rtype;
  assign is_itype_load  = ctrl.is_load;
  assign is_itype_store = ctrl.is_store;
  assign is_branch      = ctrl.is_branch;
  assign illegal        = ctrl.illegal;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage with a 1-cycle-latency instruction
// memory model; inputs change off the rising edge, outputs sampled on falling.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [9:0]  dec_pc;
  logic [31:0] dec_instr;
  logic [2:0]  ALUop;
  logic        reg_write, mem_write, mem_read, mem_to_reg, branch;
  logic        is_rtype, is_itype_load, is_itype_store, is_branch, illegal;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [1024];
  logic [12:0] ctrl;
  logic [66:0] all_out;

  // {ALUop, reg_write, mem_write, mem_read, mem_to_reg, branch,
  //  is_rtype, is_itype_load, is_itype_store, is_branch, illegal}
  localparam logic [12:0] C_ADD   = 13'b000_10000_10000;
  localparam logic [12:0] C_LW    = 13'b000_10110_01000;
  localparam logic [12:0] C_SW    = 13'b000_01000_00100;
  localparam logic [12:0] C_BEQ   = 13'b001_00001_00010;
  localparam logic [12:0] C_ILL   = 13'b000_00000_00001;
  localparam logic [12:0] C_ADDI1 = 13'b001_10000_00000;

  assign ctrl = {ALUop, reg_write, mem_write, mem_read, mem_to_reg, branch,
                 is_rtype, is_itype_load, is_itype_store, is_branch, illegal};
  assign all_out = {imem_req, imem_addr, dec_valid, dec_pc, dec_instr, ctrl};

  fetch_decode_stage #(
    .XLEN(32), .IMEM_DEPTH(1024), .QDEPTH(2), .RESET_PC(0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr),
    .ALUop          (ALUop),
    .reg_write      (reg_write),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_to_reg     (mem_to_reg),
    .branch         (branch),
    .is_rtype       (is_rtype),
    .is_itype_load  (is_itype_load),
    .is_itype_store (is_itype_store),
    .is_branch      (is_branch),
    .illegal        (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b0;
    dec_ready = ready;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL req_before_edge got=%b exp=0", imem_req);
    end
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 10'd0}) begin
      failures++; $display("FAIL first_req got=%b/%0d exp=1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [12:0] exp_ctrl [4];
    exp_ctrl = '{C_ADD, C_LW, C_SW, C_BEQ};
    do_reset(1'b1);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (k < 3) begin
        if ({dec_valid, ctrl} !== '0) begin
          failures++; $display("FAIL stream_idle k=%0d got=%b/%b exp=0", k, dec_valid, ctrl);
        end
      end else begin
        if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 10'(k-3), mem[k-3]}) begin
          failures++;
          $display("FAIL stream_pc k=%0d got=%b/%0d/%h exp=1/%0d/%h",
                   k, dec_valid, dec_pc, dec_instr, k-3, mem[k-3]);
        end
        if (k <= 6) begin
          checks++;
          if (ctrl !== exp_ctrl[k-3]) begin
            failures++; $display("FAIL stream_ctrl k=%0d got=%b exp=%b", k, ctrl, exp_ctrl[k-3]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    do_reset(1'b0);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (imem_req) nreq++;
    end
    checks++;
    if (nreq !== 2) begin
      failures++; $display("FAIL bp_req_count got=%0d exp=2", nreq);
    end
    checks++;
    if ({dec_valid, dec_pc, imem_req} !== {1'b1, 10'd0, 1'b0}) begin
      failures++;
      $display("FAIL bp_hold got=%b/%0d/%b exp=1/0/0", dec_valid, dec_pc, imem_req);
    end
    @(posedge clk); #1 dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({dec_valid, dec_pc} !== {1'b1, 10'(i)}) begin
        failures++; $display("FAIL bp_release i=%0d got=%b/%0d exp=1/%0d", i, dec_valid, dec_pc, i);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if ({dec_valid, dec_pc} !== {1'b1, 10'd0}) begin
      failures++; $display("FAIL redir_pre got=%b/%0d exp=1/0", dec_valid, dec_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 10'd100;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_req, imem_addr, dec_valid} !== {1'b1, 10'd100, 1'b0}) begin
      failures++;
      $display("FAIL redir_flush got=%b/%0d/%b exp=1/100/0", imem_req, imem_addr, dec_valid);
    end
    @(negedge clk);
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++; $display("FAIL redir_gap got=%b exp=0", dec_valid);
    end
    @(negedge clk);
    checks++;
    if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 10'd100, mem[100]}) begin
      failures++;
      $display("FAIL redir_target got=%b/%0d/%h exp=1/100/%h", dec_valid, dec_pc, dec_instr, mem[100]);
    end
    @(negedge clk);
    checks++;
    if ({dec_valid, dec_pc} !== {1'b1, 10'd101}) begin
      failures++; $display("FAIL redir_next got=%b/%0d exp=1/101", dec_valid, dec_pc);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] got  [3];
    logic [9:0] wexp [3];
    int n = 0;
    got  = '{10'h3ff, 10'h3ff, 10'h3ff};
    wexp = '{10'd1022, 10'd1023, 10'd0};
    redirect_valid = 1'b1;
    redirect_pc = 10'd1022;
    @(posedge clk); #1 redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dec_valid && n < 3) begin
        got[n] = dec_pc;
        n++;
      end
    end
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL wrap_count got=%0d exp=3", n);
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (got[j] !== wexp[j]) begin
        failures++; $display("FAIL wrap_pc j=%0d got=%0d exp=%0d", j, got[j], wexp[j]);
      end
    end
  endtask

  task automatic test_illegal_and_reset();
    int w = 0;
    dec_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 10'd200;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    while (!dec_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 10'd200, 32'h0000007f}) begin
      failures++;
      $display("FAIL ill_head got=%b/%0d/%h exp=1/200/0000007f", dec_valid, dec_pc, dec_instr);
    end
    checks++;
    if (ctrl !== C_ILL) begin
      failures++; $display("FAIL ill_ctrl got=%b exp=%b", ctrl, C_ILL);
    end
    dec_ready = 1'b1;
    @(posedge clk); #1 dec_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({dec_pc, ctrl} !== {10'd201, C_ADDI1}) begin
      failures++; $display("FAIL ialu_ctrl got=%0d/%b exp=201/%b", dec_pc, ctrl, C_ADDI1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL midrst_outputs got=%h exp=0", all_out);
    end
    dec_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (k < 3) begin
        if (dec_valid !== 1'b0) begin
          failures++; $display("FAIL midrst_no_pulse k=%0d got=%b exp=0", k, dec_valid);
        end
      end else if ({dec_valid, dec_pc, ctrl} !== {1'b1, 10'd0, C_ADD}) begin
        failures++;
        $display("FAIL midrst_restart got=%b/%0d/%b exp=1/0/%b", dec_valid, dec_pc, ctrl, C_ADD);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {20'(i), 5'd0, 7'b0010011};
    mem[0]   = 32'h003100b3;
    mem[1]   = 32'h00012083;
    mem[2]   = 32'h00112023;
    mem[3]   = 32'h00208063;
    mem[200] = 32'h0000007f;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_illegal_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
